// File: rtl/u_dat_pkg.sv
// u_dat_pkg: shared types for the data-SRAM arbiter (request payload, owner tag).
// Revision 1.0
`default_nettype none

package u_dat_pkg;

  localparam int RD_LAT_MAX = 4;

  typedef struct packed {
    logic [31:0] a;
    logic [3:0]  we;
    logic [31:0] wd;
    logic [3:0]  re;
  } dat_req_t;

  typedef enum logic {
    OWN_M0 = 1'b0,
    OWN_M1 = 1'b1
  } owner_e;

  // One slot of the read-response pipeline.
  typedef struct packed {
    logic   vld;
    owner_e own;
  } rsp_t;

endpackage

`default_nettype wire

// File: rtl/u_rr_arb2.sv
// u_rr_arb2: two-way round-robin arbiter with a registered last-grant pointer.
// Revision 1.0
`default_nettype none

module u_rr_arb2
  import u_dat_pkg::*;
(
  input  logic       clk,
  input  logic       rstn,
  input  logic [1:0] req_i,
  input  logic       adv_i,
  output logic [1:0] gnt_o,
  output owner_e     last_o
);

  owner_e last_q;
  owner_e last_d;

  always_comb begin
    gnt_o = req_i;
    // Contention goes to whichever master was not granted last.
    if (req_i == 2'b11) begin
      gnt_o = (last_q == OWN_M1) ? 2'b01 : 2'b10;
    end
    last_d = last_q;
    if (adv_i && gnt_o[0]) begin
      last_d = OWN_M0;
    end else if (adv_i && gnt_o[1]) begin
      last_d = OWN_M1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      last_q <= OWN_M1;
    end else begin
      last_q <= last_d;
    end
  end

  assign last_o = last_q;

endmodule

`default_nettype wire

// File: rtl/u_dat_arb.sv
// u_dat_arb: round-robin sharing of the single-ported data SRAM between two masters,
// with read responses routed back to the owner after RD_LAT cycles. Revision 1.0
`default_nettype none

module u_dat_arb
  import u_dat_pkg::*;
#(
  parameter int RD_LAT = 1
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        m0_req,
  input  logic [31:0] m0_a,
  input  logic [3:0]  m0_we,
  input  logic [31:0] m0_wd,
  input  logic [3:0]  m0_re,
  output logic        m0_gnt,
  output logic        m0_vld,
  output logic [31:0] m0_rd,
  input  logic        m1_req,
  input  logic [31:0] m1_a,
  input  logic [3:0]  m1_we,
  input  logic [31:0] m1_wd,
  input  logic [3:0]  m1_re,
  output logic        m1_gnt,
  output logic        m1_vld,
  output logic [31:0] m1_rd,
  output logic [31:0] dat_a,
  output logic [3:0]  dat_we,
  output logic [31:0] dat_wd,
  output logic [3:0]  dat_re,
  input  logic [31:0] dat_rd
);

  logic [1:0] gnt;
  owner_e     last;
  dat_req_t   m0_p;
  dat_req_t   m1_p;
  dat_req_t   sel_p;
  rsp_t       pipe_d;
  rsp_t       pipe_q [RD_LAT];

  assign m0_p = '{a: m0_a, we: m0_we, wd: m0_wd, re: m0_re};
  assign m1_p = '{a: m1_a, we: m1_we, wd: m1_wd, re: m1_re};

  // Every grant is a completed transfer, so the pointer always advances on one.
  u_rr_arb2 u_arb (
    .clk    (clk),
    .rstn   (rstn),
    .req_i  ({m1_req, m0_req}),
    .adv_i  (1'b1),
    .gnt_o  (gnt),
    .last_o (last)
  );

  assign m0_gnt = gnt[0];
  assign m1_gnt = gnt[1];

  always_comb begin
    sel_p = '0;
    if (gnt[0]) begin
      sel_p = m0_p;
    end else if (gnt[1]) begin
      sel_p = m1_p;
    end
    pipe_d.vld = |sel_p.re;
    pipe_d.own = gnt[1] ? OWN_M1 : OWN_M0;
  end

  assign dat_a  = sel_p.a;
  assign dat_we = sel_p.we;
  assign dat_wd = sel_p.wd;
  assign dat_re = sel_p.re;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < RD_LAT; i++) begin
        pipe_q[i] <= '0;
      end
    end else begin
      pipe_q[0] <= pipe_d;
      for (int i = 1; i < RD_LAT; i++) begin
        pipe_q[i] <= pipe_q[i-1];
      end
    end
  end

  // The tail slot lines up with dat_rd, so both masters see the SRAM data directly.
  assign m0_vld = pipe_q[RD_LAT-1].vld && (pipe_q[RD_LAT-1].own == OWN_M0);
  assign m1_vld = pipe_q[RD_LAT-1].vld && (pipe_q[RD_LAT-1].own == OWN_M1);
  assign m0_rd  = dat_rd;
  assign m1_rd  = dat_rd;

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (rstn) begin
      assert (RD_LAT >= 1 && RD_LAT <= RD_LAT_MAX);
      assert (!((|sel_p.we) && (|sel_p.re)));
      assert (gnt != 2'b11);
      assert (!(m0_req && m1_req) || ((last == OWN_M0) ? !gnt[0] : !gnt[1]));
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_u_dat_arb.sv
// tb_u_dat_arb: directed plus random checks of u_dat_arb at RD_LAT=1 and RD_LAT=3
// against a cycle-level arbitration/scoreboard model and a small SRAM model.
`default_nettype none

module tb_u_dat_arb;

  logic        clk = 1'b0;
  logic        rstn;
  logic        m0_req, m1_req;
  logic [31:0] m0_a, m0_wd, m1_a, m1_wd;
  logic [3:0]  m0_we, m0_re, m1_we, m1_re;

  logic        d1_m0_gnt, d1_m0_vld, d1_m1_gnt, d1_m1_vld;
  logic [31:0] d1_m0_rd, d1_m1_rd, d1_dat_a, d1_dat_wd, dat_rd1;
  logic [3:0]  d1_dat_we, d1_dat_re;
  logic        d3_m0_gnt, d3_m0_vld, d3_m1_gnt, d3_m1_vld;
  logic [31:0] d3_m0_rd, d3_m1_rd, d3_dat_a, d3_dat_wd, dat_rd3;
  logic [3:0]  d3_dat_we, d3_dat_re;

  always #5 clk = ~clk;

  u_dat_arb #(.RD_LAT(1)) dut1 (
    .clk(clk), .rstn(rstn),
    .m0_req(m0_req), .m0_a(m0_a), .m0_we(m0_we), .m0_wd(m0_wd), .m0_re(m0_re),
    .m0_gnt(d1_m0_gnt), .m0_vld(d1_m0_vld), .m0_rd(d1_m0_rd),
    .m1_req(m1_req), .m1_a(m1_a), .m1_we(m1_we), .m1_wd(m1_wd), .m1_re(m1_re),
    .m1_gnt(d1_m1_gnt), .m1_vld(d1_m1_vld), .m1_rd(d1_m1_rd),
    .dat_a(d1_dat_a), .dat_we(d1_dat_we), .dat_wd(d1_dat_wd), .dat_re(d1_dat_re),
    .dat_rd(dat_rd1)
  );

  u_dat_arb #(.RD_LAT(3)) dut3 (
    .clk(clk), .rstn(rstn),
    .m0_req(m0_req), .m0_a(m0_a), .m0_we(m0_we), .m0_wd(m0_wd), .m0_re(m0_re),
    .m0_gnt(d3_m0_gnt), .m0_vld(d3_m0_vld), .m0_rd(d3_m0_rd),
    .m1_req(m1_req), .m1_a(m1_a), .m1_we(m1_we), .m1_wd(m1_wd), .m1_re(m1_re),
    .m1_gnt(d3_m1_gnt), .m1_vld(d3_m1_vld), .m1_rd(d3_m1_rd),
    .dat_a(d3_dat_a), .dat_we(d3_dat_we), .dat_wd(d3_dat_wd), .dat_re(d3_dat_re),
    .dat_rd(dat_rd3)
  );

  // SRAM: 64 words, shared contents, one read pipe per latency.
  logic [31:0] mem [64];
  logic [31:0] s1;
  logic [31:0] s3 [3];
  logic        pl_en;
  logic [5:0]  pl_idx;
  logic [31:0] pl_dat;

  always @(posedge clk) begin
    s1    <= mem[d1_dat_a[7:2]];
    s3[0] <= mem[d3_dat_a[7:2]];
    s3[1] <= s3[0];
    s3[2] <= s3[1];
    if (pl_en) begin
      mem[pl_idx] <= pl_dat;
    end else begin
      for (int b = 0; b < 4; b++) begin
        if (d1_dat_we[b]) mem[d1_dat_a[7:2]][8*b +: 8] <= d1_dat_wd[8*b +: 8];
      end
    end
  end

  assign dat_rd1 = s1;
  assign dat_rd3 = s3[2];

  // Reference model: expected responses indexed by the cycle they are due.
  typedef struct {
    bit          v;
    bit          own;
    logic [31:0] d;
  } slot_t;

  slot_t       sl1 [8];
  slot_t       sl3 [8];
  logic [31:0] ref_mem [64];
  bit          last_m1;
  bit          last_g0, last_g1;
  int          cyc;
  int          nassert = 0;
  int          nfail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nassert++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic chk_rsp(input string tag, input slot_t s, input logic v0, input logic v1,
                         input logic [31:0] rd0, input logic [31:0] rd1);
    chk({tag, " m0_vld"}, 32'(v0), 32'(s.v && !s.own));
    chk({tag, " m1_vld"}, 32'(v1), 32'(s.v && s.own));
    if (s.v) begin
      if (s.own) chk({tag, " m1_rd"}, rd1, s.d);
      else       chk({tag, " m0_rd"}, rd0, s.d);
    end
  endtask

  task automatic model_reset();
    last_m1 = 1'b1;
    for (int i = 0; i < 8; i++) begin
      sl1[i].v = 1'b0;
      sl3[i].v = 1'b0;
    end
  endtask

  // One clock cycle: check at the falling edge, update the model, return at posedge+1.
  task automatic tick();
    bit          g0, g1;
    logic [31:0] ea, ewd, data;
    logic [3:0]  ewe, ere;
    int          k;
    @(negedge clk);
    g0 = m0_req && (!m1_req || last_m1);
    g1 = m1_req && (!m0_req || !last_m1);
    ea = '0; ewd = '0; ewe = '0; ere = '0;
    if (g0) begin
      ea = m0_a; ewd = m0_wd; ewe = m0_we; ere = m0_re;
    end else if (g1) begin
      ea = m1_a; ewd = m1_wd; ewe = m1_we; ere = m1_re;
    end
    chk("L1 m0_gnt", 32'(d1_m0_gnt), 32'(g0));
    chk("L1 m1_gnt", 32'(d1_m1_gnt), 32'(g1));
    chk("L3 m0_gnt", 32'(d3_m0_gnt), 32'(g0));
    chk("L3 m1_gnt", 32'(d3_m1_gnt), 32'(g1));
    chk("dat_a", d1_dat_a, ea);
    chk("dat_wd", d1_dat_wd, ewd);
    chk("dat_we", 32'(d1_dat_we), 32'(ewe));
    chk("dat_re", 32'(d1_dat_re), 32'(ere));
    k = cyc % 8;
    chk_rsp("L1", sl1[k], d1_m0_vld, d1_m1_vld, d1_m0_rd, d1_m1_rd);
    chk_rsp("L3", sl3[k], d3_m0_vld, d3_m1_vld, d3_m0_rd, d3_m1_rd);
    sl1[k].v = 1'b0;
    sl3[k].v = 1'b0;
    if (rstn && (g0 || g1)) begin
      last_m1 = g1;
      if (|ere) begin
        data = ref_mem[ea[7:2]];
        sl1[(cyc + 1) % 8] = '{v: 1'b1, own: g1, d: data};
        sl3[(cyc + 3) % 8] = '{v: 1'b1, own: g1, d: data};
      end
      for (int b = 0; b < 4; b++) begin
        if (ewe[b]) ref_mem[ea[7:2]][8*b +: 8] = ewd[8*b +: 8];
      end
    end
    last_g0 = g0;
    last_g1 = g1;
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic set_m0(input logic r, input logic [31:0] a, input logic [3:0] we,
                        input logic [31:0] wd, input logic [3:0] re);
    m0_req = r; m0_a = a; m0_we = we; m0_wd = wd; m0_re = re;
  endtask

  task automatic set_m1(input logic r, input logic [31:0] a, input logic [3:0] we,
                        input logic [31:0] wd, input logic [3:0] re);
    m1_req = r; m1_a = a; m1_we = we; m1_wd = wd; m1_re = re;
  endtask

  task automatic idle(input int n);
    m0_req = 1'b0;
    m1_req = 1'b0;
    repeat (n) tick();
  endtask

  task automatic do_reset(input int n);
    m0_req = 1'b0;
    m1_req = 1'b0;
    rstn = 1'b0;
    model_reset();
    repeat (n) tick();
    rstn = 1'b1;
  endtask

  task automatic gen(output logic [31:0] a, output logic [3:0] we,
                     output logic [31:0] wd, output logic [3:0] re);
    int kind;
    kind = $urandom_range(0, 2);
    a  = {24'h0, 6'($urandom_range(0, 63)), 2'b00};
    wd = $urandom;
    we = (kind == 1) ? 4'($urandom_range(1, 15)) : 4'h0;
    re = (kind == 0) ? 4'($urandom_range(1, 15)) : 4'h0;
  endtask

  initial begin
    logic [31:0] ra, rwd;
    logic [3:0]  rwe, rre;
    cyc = 0;
    rstn = 1'b0;
    pl_en = 1'b0; pl_idx = '0; pl_dat = '0;
    set_m0(1'b0, '0, '0, '0, '0);
    set_m1(1'b0, '0, '0, '0, '0);
    model_reset();
    @(posedge clk);
    #1;
    for (int i = 0; i < 64; i++) begin
      pl_en  = 1'b1;
      pl_idx = 6'(i);
      pl_dat = (i == 4) ? 32'hDEADBEEF : $urandom;
      ref_mem[i] = pl_dat;
      @(posedge clk);
      #1;
    end
    pl_en = 1'b0;

    // Reset state, then idle after release.
    do_reset(2);
    idle(2);

    // m0 read of the preloaded word at 0x10.
    set_m0(1'b1, 32'h10, 4'h0, 32'h0, 4'hF);
    tick();
    m0_req = 1'b0;
    chk("rd10 m0_vld", 32'(d1_m0_vld), 32'd1);
    chk("rd10 m0_rd", d1_m0_rd, 32'hDEADBEEF);
    chk("rd10 m1_vld", 32'(d1_m1_vld), 32'd0);
    idle(4);

    // Continuous contention straight after reset: m0 first, then alternate.
    do_reset(1);
    set_m0(1'b1, 32'h0, 4'h0, 32'h0, 4'hF);
    set_m1(1'b1, 32'h4, 4'h0, 32'h0, 4'hF);
    tick();
    chk("alt first m0", 32'(last_g0), 32'd1);
    repeat (5) tick();
    idle(4);

    // Full-word write by m1, then m0 reads it back.
    set_m1(1'b1, 32'h20, 4'hF, 32'hCAFEF00D, 4'h0);
    tick();
    m1_req = 1'b0;
    set_m0(1'b1, 32'h20, 4'h0, 32'h0, 4'hF);
    tick();
    m0_req = 1'b0;
    chk("wr20 m0_rd", d1_m0_rd, 32'hCAFEF00D);
    idle(4);

    // Byte-lane write merges into the existing word.
    set_m1(1'b1, 32'h20, 4'b0010, 32'h0000AB00, 4'h0);
    tick();
    m1_req = 1'b0;
    set_m0(1'b1, 32'h20, 4'h0, 32'h0, 4'hF);
    tick();
    m0_req = 1'b0;
    chk("byte m0_vld", 32'(d1_m0_vld), 32'd1);
    chk("byte m0_rd", d1_m0_rd, 32'hCAFEAB0D);
    idle(4);

    // Back-to-back interleaved reads m0, m1, m0.
    set_m0(1'b1, 32'h0, 4'h0, 32'h0, 4'hF);
    tick();
    set_m0(1'b1, 32'h8, 4'h0, 32'h0, 4'hF);
    set_m1(1'b1, 32'h4, 4'h0, 32'h0, 4'hF);
    tick();
    m1_req = 1'b0;
    tick();
    m0_req = 1'b0;
    idle(5);

    // Reset one cycle after an m0 read grant: response dropped, pointer back to m0-first.
    set_m0(1'b1, 32'hC, 4'h0, 32'h0, 4'hF);
    tick();
    do_reset(1);
    idle(4);
    set_m0(1'b1, 32'h0, 4'h0, 32'h0, 4'h0);
    set_m1(1'b1, 32'h0, 4'h0, 32'h0, 4'h0);
    tick();
    chk("post-reset m0 wins", 32'(last_g0), 32'd1);
    idle(4);

    // Random traffic: hold each request until granted, occasionally withdraw one.
    for (int n = 0; n < 400; n++) begin
      if (!m0_req || last_g0) begin
        gen(ra, rwe, rwd, rre);
        set_m0(($urandom_range(0, 3) != 0), ra, rwe, rwd, rre);
      end else if ($urandom_range(0, 15) == 0) begin
        m0_req = 1'b0;
      end
      if (!m1_req || last_g1) begin
        gen(ra, rwe, rwd, rre);
        set_m1(($urandom_range(0, 3) != 0), ra, rwe, rwd, rre);
      end else if ($urandom_range(0, 15) == 0) begin
        m1_req = 1'b0;
      end
      tick();
    end
    idle(5);

    $display("End of test - %0d assertions evaluated, %0d failures", nassert, nfail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/u_dat_arb.md
Name: u_dat_arb

Overview:
- Two-requester arbiter for the single-ported data SRAM (`dat_*` interface).
- Lets the core LSU (m0) and a secondary master (m1, debug/DMA loader) share the SRAM.
- Round-robin grant, one SRAM access per cycle.
- Read data is returned to the owning master after a fixed read latency.

Parameters:
- RD_LAT, 1, SRAM read latency in cycles, from access cycle to `dat_rd` valid; legal range 1..4.

Ports:
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- m0_req  in  1  master 0 request
- m0_a  in  32  master 0 byte address
- m0_we  in  4  master 0 byte write enables
- m0_wd  in  32  master 0 write data
- m0_re  in  4  master 0 byte read enables
- m0_gnt  out  1  master 0 request accepted this cycle
- m0_vld  out  1  master 0 read data valid
- m0_rd  out  32  master 0 read data
- m1_req, m1_a, m1_we, m1_wd, m1_re, m1_gnt, m1_vld, m1_rd: same as m0, for master 1
- dat_a  out  32  SRAM address
- dat_we  out  4  SRAM byte write enables
- dat_wd  out  32  SRAM write data
- dat_re  out  4  SRAM byte read enables
- dat_rd  in  32  SRAM read data

Behaviour:
- Reset and clock:
  - Reset rstn is asynchronous, active-low; the clock is clk.
  - Reset clears: RR pointer to "m1 last" (m0 wins the first contention), response pipeline, `m0_vld`/`m1_vld` = 0.
  - `gnt` and `dat_*` are combinational, so they are 0 whenever no req is asserted.
- Handshake:
  - A master raises `req` with payload (`a`, `we`, `wd`, `re`) and holds both stable until `gnt` is seen high in the same cycle.
  - Transfer occurs on `req && gnt`.
  - `gnt` is combinational from the reqs and the RR pointer; no registered request stage.
- Arbitration:
  - Only one requesting: it is granted.
  - Both requesting: the master not granted last wins.
  - RR pointer updates only on a grant; idle cycles leave it unchanged.
  - At most one `gnt` per cycle.
- SRAM drive:
  - Granted master's payload is routed to `dat_*` in the grant cycle.
  - No grant: `dat_we` = 0, `dat_re` = 0, `dat_a` = 0, `dat_wd` = 0.
- Writes: complete on grant; no response pulse.
- Reads (`|re` on grant):
  - Push `{valid=1, owner}` into an RD_LAT-deep shift pipeline.
  - At the tail, the owner's `mX_vld` = 1 for exactly one cycle, exactly RD_LAT cycles after the grant cycle.
- Read data:
  - `m0_rd` and `m1_rd` are both driven directly from `dat_rd`.
  - Consumers qualify data with `vld`.
- Back-to-back reads: one read per cycle, any interleaving of owners. Responses return in grant order, with no bubbles and no loss.
- Request with `we` = 0 and `re` = 0:
  - Granted as a no-op; the RR pointer still advances.
  - No SRAM enables, no `vld`.
- `we` and `re` both nonzero in one request is illegal; covered by a simulation assertion. The RTL forwards both unchanged.
- `req` dropped before `gnt`: no effect, nothing recorded.
- Reset mid-operation:
  - In-flight read responses are discarded; no `vld` is generated after reset release for pre-reset grants.
  - RR pointer returns to its reset value.

Decomposition:
- Package `u_dat_pkg`:
  - `typedef struct packed` `dat_req_t` {a[31:0], we[3:0], wd[31:0], re[3:0]}
  - `typedef enum logic` `owner_e` {OWN_M0, OWN_M1}
  - localparam `RD_LAT_MAX` = 4
- Sub-module `u_rr_arb2`: 2-way round-robin arbiter.
  - Inputs: req[1:0], an advance enable.
  - Outputs: one-hot gnt[1:0], plus the registered last-grant pointer.
- `u_dat_arb` instantiates `u_rr_arb2` and holds the mux and response pipeline.

Test Plan:
- Reset release, no reqs: all `gnt`/`vld` 0, `dat_we`/`dat_re` 0. Then m0 read of `a`=0x10 after preload 0x10=0xDEADBEEF → `m0_gnt` same cycle; `m0_vld`=1 with `m0_rd`=0xDEADBEEF exactly 1 cycle later (RD_LAT=1); `m1_vld` stays 0.
- m0 and m1 both request continuously for 6 cycles after reset → grants alternate m0,m1,m0,m1,m0,m1; never both high.
- m1 writes 0xCAFEF00D with `we`=4'b1111 to 0x20; next cycle m0 reads 0x20 → `dat_we`=4'hF in the m1 grant cycle; `m0_vld` next cycle with 0xCAFEF00D; no `m1_vld`.
- Byte write: `we`=4'b0010, `wd`=0x0000AB00 to 0x20, then read → 0xCAFEAB0D.
- RD_LAT=3, interleaved reads m0@0x0, m1@0x4, m0@0x8 on consecutive cycles → `vld` pulses m0,m1,m0 on cycles grant+3 with the matching data, no gaps.
- Read granted, rstn asserted the next cycle and released → no `vld` ever appears for that read; the first contention after reset is won by m0.
